// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB writeback has priority, MDU results wait in a
// one-entry buffer and force a one-cycle pipeline stall after STARVE_LIMIT pipe writes.
// Optional conflict/drop statistics counters are enabled by defining WBARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
`ifdef WBARB_STATS_EN
  ,
  parameter int STAT_W       = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_src,
  output logic              stall_req,
`ifdef WBARB_STATS_EN
  output logic [STAT_W-1:0] conflict_cnt,
  output logic [STAT_W-1:0] drop_cnt,
`endif
  output logic              mdu_drop
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] buf_addr_r, buf_addr_s;
  logic [DATA_W-1:0] buf_data_r, buf_data_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s;

  logic              pipe_wr_s;
  logic              mdu_acc_s;
  logic              mdu_live_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_src_s;
  logic              drop_s;
  logic              enter_pend_s;

  assign mdu_ready = reset & (state_r == ST_IDLE);
  assign stall_req = (state_r == ST_FORCE);

  assign pipe_wr_s  = pipe_we & (pipe_addr != {ADDR_W{1'b0}});
  assign mdu_acc_s  = mdu_valid & mdu_ready;
  // An accepted MDU result for r0 is swallowed here so it never buffers or drops.
  assign mdu_live_s = mdu_acc_s & (mdu_addr != {ADDR_W{1'b0}});

  // Next-state and write-port selection.
  always_comb begin
    state_s      = state_r;
    buf_addr_s   = buf_addr_r;
    buf_data_s   = buf_data_r;
    wait_cnt_s   = wait_cnt_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = rf_addr;
    wr_data_s    = rf_data;
    wr_src_s     = rf_src;
    drop_s       = 1'b0;
    enter_pend_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pipe_wr_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = pipe_addr;
          wr_data_s = pipe_data;
          wr_src_s  = 1'b0;
          if (mdu_live_s && (mdu_addr == pipe_addr)) begin
            drop_s = 1'b1;
          end else if (mdu_live_s) begin
            buf_addr_s   = mdu_addr;
            buf_data_s   = mdu_data;
            wait_cnt_s   = {CNT_W{1'b0}};
            enter_pend_s = 1'b1;
            state_s      = ST_PEND;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (mdu_live_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = mdu_addr;
          wr_data_s = mdu_data;
          wr_src_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!pipe_wr_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = buf_addr_r;
          wr_data_s = buf_data_r;
          wr_src_s  = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          wr_en_s   = 1'b1;
          wr_addr_s = pipe_addr;
          wr_data_s = pipe_data;
          wr_src_s  = 1'b0;
          if (pipe_addr == buf_addr_r) begin
            drop_s     = 1'b1;
            wait_cnt_s = {CNT_W{1'b0}};
            state_s    = ST_IDLE;
          end else begin
            wait_cnt_s = wait_cnt_r + CNT_W'(1);
            if ((wait_cnt_r + CNT_W'(1)) == LIMIT_C) begin
              state_s = ST_FORCE;
            end else begin
              state_s = ST_PEND;
            end
          end
        end
      end
      ST_FORCE: begin
        // Pipeline is frozen this cycle and will re-present its write.
        wr_en_s    = 1'b1;
        wr_addr_s  = buf_addr_r;
        wr_data_s  = buf_data_r;
        wr_src_s   = 1'b1;
        wait_cnt_s = {CNT_W{1'b0}};
        state_s    = ST_IDLE;
      end
      default: begin
        wait_cnt_s = {CNT_W{1'b0}};
        state_s    = ST_IDLE;
      end
    endcase
  end

  // Control state and holding buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      buf_addr_r <= {ADDR_W{1'b0}};
      buf_data_r <= {DATA_W{1'b0}};
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      buf_addr_r <= buf_addr_s;
      buf_data_r <= buf_data_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Registered register-file write port and drop pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_addr  <= {ADDR_W{1'b0}};
      rf_data  <= {DATA_W{1'b0}};
      rf_src   <= 1'b0;
      mdu_drop <= 1'b0;
    end else begin
      rf_we    <= wr_en_s;
      rf_addr  <= wr_addr_s;
      rf_data  <= wr_data_s;
      rf_src   <= wr_src_s;
      mdu_drop <= drop_s;
    end
  end

`ifdef WBARB_STATS_EN
  // Saturating statistics, aligned with the visible drop pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= {STAT_W{1'b0}};
      drop_cnt     <= {STAT_W{1'b0}};
    end else begin
      if (enter_pend_s && (conflict_cnt != {STAT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + STAT_W'(1);
      end else begin
        conflict_cnt <= conflict_cnt;
      end
      if (drop_s && (drop_cnt != {STAT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + STAT_W'(1);
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

  logic        clock;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_src;
  logic        stall_req;
  logic        mdu_drop;
`ifdef WBARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] drop_cnt;
`endif

  int checks;
  int failures;
  logic [37:0] exp_rf;
  logic [3:0]  exp_ctl;
  wire  [37:0] got_rf  = {rf_src, rf_addr, rf_data};
  wire  [3:0]  got_ctl = {rf_we, mdu_ready, stall_req, mdu_drop};

  wb_port_arbiter dut (
    .clock(clock), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_src(rf_src), .stall_req(stall_req),
`ifdef WBARB_STATS_EN
    .conflict_cnt(conflict_cnt), .drop_cnt(drop_cnt),
`endif
    .mdu_drop(mdu_drop)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic set_pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_we = 1'b1; pipe_addr = a; pipe_data = d;
  endtask

  task automatic set_mdu(input logic [4:0] a, input logic [31:0] d);
    mdu_valid = 1'b1; mdu_addr = a; mdu_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    exp_ctl = 4'b0000;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    reset = 1'b1;
    #1;
    exp_ctl = 4'b0100;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL release_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    exp_rf = 38'd0;
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL reset_rf got=%h exp=%h", got_rf, exp_rf); end
  endtask

  task automatic test_bypass();
    set_mdu(5'd7, 32'h1234);
    tick();
    idle_inputs();
    exp_ctl = 4'b1100; exp_rf = {1'b1, 5'd7, 32'h1234};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL bypass_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL bypass_rf got=%h exp=%h", got_rf, exp_rf); end
    tick();
    exp_ctl = 4'b0100;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL bypass_after_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL bypass_hold_rf got=%h exp=%h", got_rf, exp_rf); end
  endtask

  task automatic test_buffer_drain();
    set_pipe(5'd3, 32'hAA);
    set_mdu(5'd9, 32'h55);
    tick();
    idle_inputs();
    exp_ctl = 4'b1000; exp_rf = {1'b0, 5'd3, 32'hAA};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL buf_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL buf_rf got=%h exp=%h", got_rf, exp_rf); end
    tick();
    exp_ctl = 4'b1100; exp_rf = {1'b1, 5'd9, 32'h55};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL drain_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL drain_rf got=%h exp=%h", got_rf, exp_rf); end
    tick();
    exp_ctl = 4'b0100;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL drain_quiet_ctl got=%b exp=%b", got_ctl, exp_ctl); end
  endtask

  // Buffers MDU r9 beside pipe r8, then starves it with pipe r1..r4.
  task automatic starve_to_force();
    set_pipe(5'd8, 32'h80);
    set_mdu(5'd9, 32'h99);
    tick();
    mdu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_pipe(5'(i), 32'h11 * i);
      tick();
      exp_ctl = (i == 4) ? 4'b1010 : 4'b1000;
      exp_rf  = {1'b0, 5'(i), 32'h11 * i};
      checks++;
      if (got_ctl !== exp_ctl) begin failures++; $display("FAIL starve_ctl_%0d got=%b exp=%b", i, got_ctl, exp_ctl); end
      checks++;
      if (got_rf !== exp_rf) begin failures++; $display("FAIL starve_rf_%0d got=%h exp=%h", i, got_rf, exp_rf); end
    end
  endtask

  task automatic test_starvation();
    starve_to_force();
    set_pipe(5'd5, 32'h5555);
    tick();
    exp_ctl = 4'b1100; exp_rf = {1'b1, 5'd9, 32'h99};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL force_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL force_rf got=%h exp=%h", got_rf, exp_rf); end
    tick();
    idle_inputs();
    exp_ctl = 4'b1100; exp_rf = {1'b0, 5'd5, 32'h5555};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL replay_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL replay_rf got=%h exp=%h", got_rf, exp_rf); end
    tick();
  endtask

  task automatic test_supersede();
    set_pipe(5'd2, 32'h22);
    set_mdu(5'd6, 32'h66);
    tick();
    mdu_valid = 1'b0;
    set_pipe(5'd6, 32'h77);
    tick();
    idle_inputs();
    exp_ctl = 4'b1101; exp_rf = {1'b0, 5'd6, 32'h77};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL supersede_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL supersede_rf got=%h exp=%h", got_rf, exp_rf); end
`ifdef WBARB_STATS_EN
    checks++;
    if ({conflict_cnt, drop_cnt} !== {16'd3, 16'd1}) begin
      failures++; $display("FAIL supersede_stats got=%0d/%0d exp=3/1", conflict_cnt, drop_cnt);
    end
`endif
    tick();
    exp_ctl = 4'b0100;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL supersede_empty_ctl got=%b exp=%b", got_ctl, exp_ctl); end
  endtask

  task automatic test_same_addr();
    set_pipe(5'd4, 32'h44);
    set_mdu(5'd4, 32'h99);
    tick();
    idle_inputs();
    exp_ctl = 4'b1101; exp_rf = {1'b0, 5'd4, 32'h44};
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL same_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    checks++;
    if (got_rf !== exp_rf) begin failures++; $display("FAIL same_rf got=%h exp=%h", got_rf, exp_rf); end
`ifdef WBARB_STATS_EN
    checks++;
    if (drop_cnt !== 16'd2) begin failures++; $display("FAIL same_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    tick();
    exp_ctl = 4'b0100;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL same_after_ctl got=%b exp=%b", got_ctl, exp_ctl); end
  endtask

  task automatic test_addr_zero();
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hDEAD;
    set_mdu(5'd0, 32'hBEEF);
    tick();
    idle_inputs();
    exp_ctl = 4'b0100;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL zero_ctl got=%b exp=%b", got_ctl, exp_ctl); end
  endtask

  task automatic test_reset_in_force();
    starve_to_force();
    set_pipe(5'd5, 32'h5555);
    #3;
    reset = 1'b0;
    #1;
    exp_ctl = 4'b0000;
    checks++;
    if (got_ctl !== exp_ctl) begin failures++; $display("FAIL force_reset_ctl got=%b exp=%b", got_ctl, exp_ctl); end
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_ctl = 4'b0100;
      checks++;
      if (got_ctl !== exp_ctl) begin failures++; $display("FAIL post_reset_ctl_%0d got=%b exp=%b", i, got_ctl, exp_ctl); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_buffer_drain();
    test_starvation();
    test_supersede();
    test_same_addr();
    test_addr_zero();
    test_reset_in_force();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
